// File: rtl/pattern_count_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : pattern_count_seq_if
// Description : Shared single-port data-memory bus driven by the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pattern_count_seq_if;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;

    modport master (
        output mem_addr,
        output mem_rd_en,
        output mem_wr_en,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/pattern_count_seq.sv
`default_nettype none
// ============================================================================
// Module      : pattern_count_seq
// Description : Reads a 5-bit pattern and a message string from memory, counts
//               in-byte / any-in-byte / stream-wide matches, writes them back.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_count_seq #(
    parameter int STR_BASE = 0,
    parameter int STR_LEN  = 32,
    parameter int PAT_ADDR = 32,
    parameter int RES_ADDR = 33
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                i_start,
    output logic                     o_done,
    output logic                     o_busy,
    pattern_count_seq_if.master      bus
);

    localparam int              KW        = $clog2(STR_LEN + 1);
    localparam logic [KW-1:0]   c_K_LAST  = KW'(STR_LEN);
    localparam logic [KW-1:0]   c_K_ONE   = KW'(1);
    localparam logic [7:0]      c_PAT_A   = 8'(PAT_ADDR);
    localparam logic [7:0]      c_STR_A   = 8'(STR_BASE);
    localparam logic [7:0]      c_RES0_A  = 8'(RES_ADDR);
    localparam logic [7:0]      c_RES1_A  = 8'(RES_ADDR + 1);
    localparam logic [7:0]      c_RES2_A  = 8'(RES_ADDR + 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PAT  = 3'd1,
        S_SCAN = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_WR2  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_busy;
    logic           r_done;

    logic [KW-1:0]  r_k;
    logic [4:0]     r_pat;
    logic [7:0]     r_prev;
    logic [7:0]     r_ctb;
    logic [7:0]     r_cto;
    logic [7:0]     r_cts;

    logic [7:0]     w_addr;
    logic           w_rd_en;
    logic           w_wr_en;
    logic [7:0]     w_wdata;
    logic           w_accept;

    logic [7:0]     w_b;
    logic [3:0]     w_in_hit;
    logic [3:0]     w_x_hit;
    logic [2:0]     w_in_cnt;
    logic [2:0]     w_x_cnt;
    logic           w_cross_en;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;

    // ------------------------------------------------------------------------
    // Next state and memory-port decode (state and k only, never mem_rdata)
    // ------------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_addr  = 8'd0;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        w_wdata = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_PAT;
            end
            S_PAT: begin
                w_addr  = c_PAT_A;
                w_rd_en = 1'b1;
                w_next  = S_SCAN;
            end
            S_SCAN: begin
                if (r_k != c_K_LAST) begin
                    w_addr  = c_STR_A + 8'(r_k);
                    w_rd_en = 1'b1;
                end else begin
                    w_next  = S_WR0;
                end
            end
            S_WR0: begin
                w_addr  = c_RES0_A;
                w_wr_en = 1'b1;
                w_wdata = r_ctb;
                w_next  = S_WR1;
            end
            S_WR1: begin
                w_addr  = c_RES1_A;
                w_wr_en = 1'b1;
                w_wdata = r_cto;
                w_next  = S_WR2;
            end
            S_WR2: begin
                w_addr  = c_RES2_A;
                w_wr_en = 1'b1;
                w_wdata = r_cts;
                w_next  = S_DONE;
            end
            S_DONE: begin
                if (i_start) w_next = S_PAT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.mem_addr  = w_addr;
    assign bus.mem_rd_en = w_rd_en;
    assign bus.mem_wr_en = w_wr_en;
    assign bus.mem_wdata = w_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done  <= (w_next == S_DONE);
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

    // ------------------------------------------------------------------------
    // Window matching on the byte returned for the previous cycle's read
    // ------------------------------------------------------------------------
    assign w_b = bus.mem_rdata;

    assign w_in_hit[3] = (w_b[7:3] == r_pat);
    assign w_in_hit[2] = (w_b[6:2] == r_pat);
    assign w_in_hit[1] = (w_b[5:1] == r_pat);
    assign w_in_hit[0] = (w_b[4:0] == r_pat);

    assign w_x_hit[3]  = ({r_prev[3:0], w_b[7]}   == r_pat);
    assign w_x_hit[2]  = ({r_prev[2:0], w_b[7:6]} == r_pat);
    assign w_x_hit[1]  = ({r_prev[1:0], w_b[7:5]} == r_pat);
    assign w_x_hit[0]  = ({r_prev[0],   w_b[7:4]} == r_pat);

    always_comb begin
        w_in_cnt = 3'd0;
        w_x_cnt  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            w_in_cnt = w_in_cnt + 3'(w_in_hit[i]);
            w_x_cnt  = w_x_cnt  + 3'(w_x_hit[i]);
        end
    end

    // The first message byte has no predecessor, so it only has in-byte windows
    assign w_cross_en = (r_k != c_K_ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k    <= '0;
            r_pat  <= 5'd0;
            r_prev <= 8'd0;
            r_ctb  <= 8'd0;
            r_cto  <= 8'd0;
            r_cts  <= 8'd0;
        end else if (w_accept) begin
            r_k    <= '0;
            r_pat  <= 5'd0;
            r_prev <= 8'd0;
            r_ctb  <= 8'd0;
            r_cto  <= 8'd0;
            r_cts  <= 8'd0;
        end else if (r_state == S_PAT) begin
            r_k    <= '0;
        end else if (r_state == S_SCAN) begin
            if (r_k == '0) begin
                r_pat  <= w_b[4:0];
            end else begin
                r_ctb  <= r_ctb + 8'(w_in_cnt);
                r_cto  <= r_cto + 8'(w_in_cnt != 3'd0);
                r_cts  <= r_cts + 8'(w_in_cnt) + (w_cross_en ? 8'(w_x_cnt) : 8'd0);
                r_prev <= w_b;
            end
            if (r_k != c_K_LAST) r_k <= r_k + c_K_ONE;
        end
    end

endmodule
`default_nettype wire

// File: doc/pattern_count_seq.md
# pattern_count_seq

Hardware sequencer for the 5-bit pattern search ("program 3") task. On a start pulse it reads the pattern and the 32-byte message string from data memory over a single shared read/write port. It computes three match counts and writes them back to data memory, then raises `done`. It sits beside the core as a memory-port master and replaces the software loop.

## Interface
Parameters:
- `STR_BASE`, 0: address of message byte 0; byte 0 is the most significant byte of the bit stream.
- `STR_LEN`, 32: number of message bytes.
- `PAT_ADDR`, 32: pattern byte address; pattern = bits [4:0], bits [7:5] ignored.
- `RES_ADDR`, 33: first result address; results go to RES_ADDR, +1, +2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request pulse.
- `done` out 1: high from job completion until next accepted start or reset.
- `busy` out 1: high in every state except IDLE and DONE.
- `mem_addr` out 8: memory address.
- `mem_rd_en` out 1: read strobe; data returns on `mem_rdata` the next cycle.
- `mem_rdata` in 8: read data, 1-cycle latency.
- `mem_wr_en` out 1: write strobe, written at the clock edge.
- `mem_wdata` out 8: write data.

## Operation
- States: IDLE, PAT, SCAN, WR0, WR1, WR2, DONE.
- IDLE: on `start`, clear all counters and the previous-byte register, then go to PAT.
- PAT (1 cycle): `mem_addr`=PAT_ADDR, `mem_rd_en`=1, k←0, then go to SCAN.
- SCAN, k = 0..STR_LEN:
  - If k<STR_LEN: `mem_addr`=STR_BASE+k, `mem_rd_en`=1.
  - k=0: latch `pat`←`mem_rdata[4:0]`.
  - k≥1: process byte b=`mem_rdata` (message byte k-1).
  - k=STR_LEN: go to WR0.
- Byte processing:
  - In-byte windows: b[7:3], b[6:2], b[5:1], b[4:0]. `ctb` += number of in-byte windows equal to `pat`. `cto` += 1 if any in-byte window matches.
  - Crossing windows (only when k≥2): with p = previous byte, {p[3:0],b[7]}, {p[2:0],b[7:6]}, {p[1:0],b[7:5]}, {p[0],b[7:4]}. `cts` += in-byte matches + crossing matches.
  - Byte 0 contributes in-byte windows only. Total windows examined = 4·32 + 4·31 = 252.
  - Store p←b.
- Counter widths: all counters 8 bits. Maxima: ctb 128, cto 32, cts 252. No saturation logic is needed.
- WR0/WR1/WR2 each assert `mem_wr_en`=1:
  - WR0: addr RES_ADDR, data ctb.
  - WR1: addr RES_ADDR+1, data cto.
  - WR2: addr RES_ADDR+2, data cts.
- After WR2, go to DONE with `done`=1.
- DONE: hold `done`. On `start`, clear counters, drop `done`, go to PAT.
- `start` is ignored in PAT, SCAN and WR*.
- `mem_rd_en` and `mem_wr_en` are never high together. In IDLE and DONE, addr, wdata and both strobes are 0.

## Timing
- Reset (asynchronous assert, synchronous deassert by the environment): state IDLE; `done`=0, `busy`=0, `mem_*` outputs 0, counters 0.
- Reset mid-job: immediate return to IDLE. No further reads or writes. Partial results are never written.
- Start accepted at edge t: PAT occupies t..t+1. SCAN covers edges t+2..t+34 (33 cycles). WR0/WR1/WR2 writes occur at edges t+35, t+36, t+37. `done` goes high after edge t+37 and stays high.
- Outputs `mem_*` are combinational from state and k only; there is no combinational path from `mem_rdata`.
- `busy` and `done` are registered state decodes.

## Test plan
- All bytes 0x00, pattern byte 0x00 → mem[33]=128, mem[34]=32, mem[35]=252; `done` rises 37 cycles after the start edge.
- All bytes 0x55, pattern 0x0A → 64, 32, 126.
- mem[0]=0x03, mem[1]=0xE0, rest 0x00, pattern 0x1F → 0, 0, 1 (one crossing match only). Pattern byte 0xFF gives the same result, confirming bits [7:5] are ignored.
- All bytes 0xFF, pattern 0x1F; pulse `start` again during SCAN → ignored; results 128, 32, 252 at the original timing.
- Assert `reset` low at SCAN k=10 → `busy`/`done` 0 immediately, no writes to 33–35. A fresh start then completes normally.
- Back-to-back jobs: start in DONE with a new pattern → `done` drops next cycle, and the new counts are written without residue from the previous job.
